// File: rtl/rv0_wbu_pkg.sv
// rv0_wbu_pkg: types shared by the writeback unit and its retire FIFO.
//   XLEN          integer register width
//   opcode_e      RV32 major opcodes seen at writeback
//   wb_entry_t    retire FIFO entry {we, rd, wdata}
//   decode_result builds a retire entry from an instruction's low bits and its result
package rv0_wbu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } wb_entry_t;

    // Only register-producing opcodes write, and never to x0. The scoreboard
    // still needs rd for every entry, so rd is carried regardless of we.
    function automatic wb_entry_t decode_result(input logic [6:0]      opcode,
                                                input logic [4:0]      rd,
                                                input logic [XLEN-1:0] wdata);
        wb_entry_t e;
        e.rd    = rd;
        e.wdata = wdata;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LOAD: e.we = (rd != 5'd0);
            default:                      e.we = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rv0_wbu_fifo.sv
// rv0_wbu_fifo: synchronous retire FIFO of wb_entry_t.
//   clk, rst_n      clock, synchronous active-low reset
//   push, wentry    write request and data (caller guarantees space)
//   pop, rentry     read request and head entry (caller guarantees non-empty)
//   full, empty     status
//   count           number of entries held, 0..WB_DEPTH
// WB_DEPTH must be a power of two so the pointers wrap naturally.
module rv0_wbu_fifo
    import rv0_wbu_pkg::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     wentry,
    input  logic                          pop,
    output wb_entry_t                     rentry,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(WB_DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);

    wb_entry_t         mem [WB_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wentry;
    end

    assign rentry = mem[rd_ptr];
    assign full   = (count == CW'(WB_DEPTH));
    assign empty  = (count == '0);

endmodule

// File: rtl/rv0_wbu.sv
// rv0_wbu: writeback stage. Accepts results from the EXU and LSU result buffers,
// round-robin arbitrates, queues them in a retire FIFO and drains one entry per
// cycle into the register file while releasing the IDU scoreboard.
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   exu_insn_i/addr_i/wdata_i/rdy_i     EXU result, held until exu_ack_o
//   exu_ack_o                           one-cycle accept pulse
//   lsu_*                               same for the LSU
//   rf_we_o, rf_waddr_o, rf_wdata_o     register-file write port
//   sb_clr_o, sb_clr_addr_o             scoreboard release pulse and register
//   instret_o                           retired count, only with RV0_WBU_INSTRET_EN
// Optional feature macro: RV0_WBU_INSTRET_EN.
module rv0_wbu
    import rv0_wbu_pkg::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
`ifdef RV0_WBU_INSTRET_EN
    output logic [63:0]     instret_o,
`endif
    input  logic [31:0]     exu_insn_i,
    input  logic [XLEN-1:0] exu_addr_i,
    input  logic [XLEN-1:0] exu_wdata_i,
    input  logic            exu_rdy_i,
    output logic            exu_ack_o,
    input  logic [31:0]     lsu_insn_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic            lsu_rdy_i,
    output logic            lsu_ack_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            sb_clr_o,
    output logic [4:0]      sb_clr_addr_o
);

    logic                          exu_req;
    logic                          lsu_req;
    logic                          space;
    logic                          grant_exu;
    logic                          grant_lsu;
    logic                          push;
    logic                          pop;
    logic                          full;
    logic                          empty;
    logic                          rr_lsu;
    logic [11:0]                   sel_insn;
    logic [XLEN-1:0]               sel_wdata;
    wb_entry_t                     new_entry;
    wb_entry_t                     head;
    logic [$clog2(WB_DEPTH+1)-1:0] fifo_count;
    logic                          unused_bits;

    // A channel whose ack is high is mid-handshake and must not be resampled.
    assign exu_req = exu_rdy_i & ~exu_ack_o;
    assign lsu_req = lsu_rdy_i & ~lsu_ack_o;

    // The RF always accepts, so a non-empty FIFO pops every cycle.
    assign pop   = ~empty;
    assign space = ~full | pop;

    assign grant_exu = space & exu_req & (~lsu_req | ~rr_lsu);
    assign grant_lsu = space & lsu_req & (~exu_req |  rr_lsu);
    assign push      = grant_exu | grant_lsu;

    always_comb begin
        sel_insn  = exu_insn_i[11:0];
        sel_wdata = exu_wdata_i;
        if (grant_lsu) begin
            sel_insn  = lsu_insn_i[11:0];
            sel_wdata = lsu_wdata_i;
        end
        new_entry = decode_result(sel_insn[6:0], sel_insn[11:7], sel_wdata);
    end

    rv0_wbu_fifo #(
        .WB_DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .push   (push),
        .wentry (new_entry),
        .pop    (pop),
        .rentry (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            exu_ack_o     <= 1'b0;
            lsu_ack_o     <= 1'b0;
            rr_lsu        <= 1'b0;
            rf_we_o       <= 1'b0;
            rf_waddr_o    <= '0;
            rf_wdata_o    <= '0;
            sb_clr_o      <= 1'b0;
            sb_clr_addr_o <= '0;
        end else begin
            exu_ack_o <= grant_exu;
            lsu_ack_o <= grant_lsu;
            // Point at the channel that did not just win.
            if (grant_exu)      rr_lsu <= 1'b1;
            else if (grant_lsu) rr_lsu <= 1'b0;
            if (pop) begin
                rf_we_o       <= head.we;
                rf_waddr_o    <= head.rd;
                rf_wdata_o    <= head.wdata;
                sb_clr_o      <= 1'b1;
                sb_clr_addr_o <= head.rd;
            end else begin
                rf_we_o  <= 1'b0;
                sb_clr_o <= 1'b0;
            end
        end
    end

`ifdef RV0_WBU_INSTRET_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni)  instret_o <= '0;
        else if (pop) instret_o <= instret_o + 64'd1;
    end
`endif

    // Instruction address and upper insn bits are not needed at writeback.
    assign unused_bits = ^{exu_addr_i, lsu_addr_i, exu_insn_i[31:12],
                           lsu_insn_i[31:12], fifo_count};

endmodule

// File: tb/tb_rv0_wbu.sv
module tb_rv0_wbu;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    typedef struct packed {
        logic [6:0] opc;
        logic [4:0] rd;
        logic       we;
    } item_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] exu_insn_i, exu_addr_i, exu_wdata_i;
    logic        exu_rdy_i;
    logic        exu_ack_o;
    logic [31:0] lsu_insn_i, lsu_addr_i, lsu_wdata_i;
    logic        lsu_rdy_i;
    logic        lsu_ack_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        sb_clr_o;
    logic [4:0]  sb_clr_addr_o;
`ifdef RV0_WBU_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t mon_e;
    int   acks;

    always #5 clk_i = ~clk_i;

    rv0_wbu dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
`ifdef RV0_WBU_INSTRET_EN
        .instret_o     (instret_o),
`endif
        .exu_insn_i    (exu_insn_i),
        .exu_addr_i    (exu_addr_i),
        .exu_wdata_i   (exu_wdata_i),
        .exu_rdy_i     (exu_rdy_i),
        .exu_ack_o     (exu_ack_o),
        .lsu_insn_i    (lsu_insn_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_rdy_i     (lsu_rdy_i),
        .lsu_ack_o     (lsu_ack_o),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .sb_clr_o      (sb_clr_o),
        .sb_clr_addr_o (sb_clr_addr_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] opc, input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom();
        return {r[31:12], rd, opc};
    endfunction

    // Scoreboard: every scoreboard release pops one expected entry.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && sb_clr_o === 1'b1) begin
            if (sbq.size() == 0) begin
                check_val("unexpected_pop", 64'(1), 64'(0));
            end else begin
                mon_e = sbq.pop_front();
                check_val("rf_we",       64'(rf_we_o),       64'(mon_e.we));
                check_val("rf_waddr",    64'(rf_waddr_o),    64'(mon_e.rd));
                check_val("rf_wdata",    64'(rf_wdata_o),    64'(mon_e.wd));
                check_val("sb_clr_addr", 64'(sb_clr_addr_o), 64'(mon_e.rd));
            end
        end
    end

    // Present one result on a channel (0=EXU, 1=LSU) and wait for its ack.
    task automatic send(input int ch, input logic [31:0] insn, input logic [31:0] wd);
        if (ch == 0) begin
            exu_insn_i = insn; exu_wdata_i = wd; exu_addr_i = $urandom(); exu_rdy_i = 1'b1;
        end else begin
            lsu_insn_i = insn; lsu_wdata_i = wd; lsu_addr_i = $urandom(); lsu_rdy_i = 1'b1;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if ((ch == 0 && exu_ack_o === 1'b1) || (ch == 1 && lsu_ack_o === 1'b1)) begin
                if (ch == 0) exu_rdy_i = 1'b0; else lsu_rdy_i = 1'b0;
                return;
            end
        end
        check_val("ack_timeout", 64'(0), 64'(1));
        if (ch == 0) exu_rdy_i = 1'b0; else lsu_rdy_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t e_tab [8];
        item_t l_tab [8];
        logic [31:0] insn;

        e_tab = '{'{OP_IMM, 5'd5, 1'b1}, '{LUI, 5'd1, 1'b1}, '{AUIPC, 5'd31, 1'b1},
                  '{JAL, 5'd0, 1'b0}, '{JALR, 5'd3, 1'b1}, '{OP, 5'd7, 1'b1},
                  '{BRANCH, 5'd9, 1'b0}, '{SYSTEM, 5'd2, 1'b0}};
        l_tab = '{'{LOAD, 5'd4, 1'b1}, '{LOAD, 5'd0, 1'b0}, '{STORE, 5'd6, 1'b0},
                  '{LOAD, 5'd8, 1'b1}, '{LOAD, 5'd31, 1'b1}, '{STORE, 5'd1, 1'b0},
                  '{LOAD, 5'd12, 1'b1}, '{LOAD, 5'd13, 1'b1}};

        rst_ni = 1'b0;
        exu_insn_i = '0; exu_addr_i = '0; exu_wdata_i = '0; exu_rdy_i = 1'b0;
        lsu_insn_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_rdy_i = 1'b0;
        idle(3);
        rst_ni = 1'b1;

        // Reset state
        check_val("rst_exu_ack",  64'(exu_ack_o),     64'(0));
        check_val("rst_lsu_ack",  64'(lsu_ack_o),     64'(0));
        check_val("rst_rf_we",    64'(rf_we_o),       64'(0));
        check_val("rst_rf_waddr", 64'(rf_waddr_o),    64'(0));
        check_val("rst_rf_wdata", 64'(rf_wdata_o),    64'(0));
        check_val("rst_sb_clr",   64'(sb_clr_o),      64'(0));
        check_val("rst_sb_addr",  64'(sb_clr_addr_o), 64'(0));
`ifdef RV0_WBU_INSTRET_EN
        check_val("rst_instret", instret_o, 64'(0));
`endif

        // Both channels always ready: pointer starts at EXU, so E,L,E,L...
        for (int i = 0; i < 8; i++) begin
            sbq.push_back('{e_tab[i].we, e_tab[i].rd, 32'hE000_0000 + 32'(i)});
            sbq.push_back('{l_tab[i].we, l_tab[i].rd, 32'hA000_0000 + 32'(i)});
        end
        fork
            for (int i = 0; i < 8; i++)
                send(0, mk_insn(e_tab[i].opc, e_tab[i].rd), 32'hE000_0000 + 32'(i));
            for (int j = 0; j < 8; j++)
                send(1, mk_insn(l_tab[j].opc, l_tab[j].rd), 32'hA000_0000 + 32'(j));
        join
        idle(4);
        check_val("alt_drained", 64'(sbq.size()), 64'(0));

        // ADDI x5, x0, 0x10: ack at +1, RF write at +2
        sbq.push_back('{1'b1, 5'd5, 32'h0000_0010});
        exu_insn_i = {12'h010, 5'd0, 3'b000, 5'd5, OP_IMM};
        exu_wdata_i = 32'h0000_0010;
        exu_rdy_i = 1'b1;
        @(negedge clk_i);
        check_val("lat_ack1",  64'(exu_ack_o), 64'(1));
        check_val("lat_we1",   64'(rf_we_o),   64'(0));
        exu_rdy_i = 1'b0;
        @(negedge clk_i);
        check_val("lat_ack2",  64'(exu_ack_o), 64'(0));
        check_val("lat_we2",   64'(rf_we_o),   64'(1));
        check_val("lat_waddr", 64'(rf_waddr_o), 64'(5));
        check_val("lat_wdata", 64'(rf_wdata_o), 64'(32'h10));
        idle(3);

        // rdy held through the ack cycle, dropped before the next sample: one entry
        sbq.push_back('{1'b1, 5'd10, 32'h0000_1234});
        exu_insn_i = mk_insn(OP, 5'd10); exu_wdata_i = 32'h0000_1234; exu_rdy_i = 1'b1;
        acks = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_i);
            if (exu_ack_o === 1'b1) acks++;
            if (i == 2) exu_rdy_i = 1'b0;
        end
        check_val("hold_one_acks", 64'(acks), 64'(1));

        // rdy still high on the following sample cycle: captured a second time
        sbq.push_back('{1'b1, 5'd11, 32'h0000_5678});
        sbq.push_back('{1'b1, 5'd11, 32'h0000_5678});
        exu_insn_i = mk_insn(OP, 5'd11); exu_wdata_i = 32'h0000_5678; exu_rdy_i = 1'b1;
        acks = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_i);
            if (exu_ack_o === 1'b1) acks++;
            if (i == 3) exu_rdy_i = 1'b0;
        end
        check_val("hold_two_acks", 64'(acks), 64'(2));
        idle(2);

        // Non-writing entries still release the scoreboard with their rd field
        sbq.push_back('{1'b0, 5'd11, 32'hB0B0_0001});
        send(0, mk_insn(BRANCH, 5'd11), 32'hB0B0_0001);
        sbq.push_back('{1'b0, 5'd21, 32'h5705_0002});
        send(1, mk_insn(STORE, 5'd21), 32'h5705_0002);
        sbq.push_back('{1'b0, 5'd0, 32'h0000_0003});
        send(0, {12'h003, 5'd0, 3'b000, 5'd0, OP_IMM}, 32'h0000_0003);
        sbq.push_back('{1'b0, 5'd0, 32'h0000_0004});
        send(1, mk_insn(LOAD, 5'd0), 32'h0000_0004);
        idle(4);
        check_val("nowr_drained", 64'(sbq.size()), 64'(0));

        // Fill the FIFO with draining stalled, then present a third result
        force dut.pop = 1'b0;
        sbq.push_back('{1'b1, 5'd14, 32'hF111_0001});
        send(0, mk_insn(LUI, 5'd14), 32'hF111_0001);
        sbq.push_back('{1'b1, 5'd15, 32'hF111_0002});
        send(1, mk_insn(LOAD, 5'd15), 32'hF111_0002);
        sbq.push_back('{1'b1, 5'd16, 32'hF111_0003});
        exu_insn_i = mk_insn(JALR, 5'd16); exu_wdata_i = 32'hF111_0003; exu_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_val("full_no_ack", 64'(exu_ack_o), 64'(0));
        end
        release dut.pop;
        @(negedge clk_i);
        check_val("full_pushpop_ack", 64'(exu_ack_o), 64'(1));
        exu_rdy_i = 1'b0;
        idle(5);
        check_val("full_drained", 64'(sbq.size()), 64'(0));

        // Reset with two entries queued: they are discarded
        force dut.pop = 1'b0;
        send(0, mk_insn(OP, 5'd20), 32'hDEAD_0001);
        send(1, mk_insn(LOAD, 5'd21), 32'hDEAD_0002);
        rst_ni = 1'b0;
        release dut.pop;
        @(negedge clk_i);
        check_val("rstq_rf_we",   64'(rf_we_o),   64'(0));
        check_val("rstq_sb_clr",  64'(sb_clr_o),  64'(0));
        check_val("rstq_exu_ack", 64'(exu_ack_o), 64'(0));
`ifdef RV0_WBU_INSTRET_EN
        check_val("rstq_instret", instret_o, 64'(0));
`endif
        rst_ni = 1'b1;
        idle(4);
        for (int i = 1; i <= 3; i++) begin
            insn = mk_insn(OP_IMM, 5'(i));
            sbq.push_back('{1'b1, 5'(i), 32'hC000_0000 + 32'(i)});
            send(i % 2, insn, 32'hC000_0000 + 32'(i));
        end
        idle(4);
`ifdef RV0_WBU_INSTRET_EN
        check_val("instret_3", instret_o, 64'(3));
`endif
        check_val("final_drained", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
